// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan controller: special digit codes, the
// code-to-segment table and a width helper.
package seg7_pkg;

  localparam logic [3:0] BLANK = 4'hA;
  localparam logic [3:0] DASH  = 4'hB;

  // Indexed by digit code; bit 0 = segment a, active-high. DASH lights g only.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h00, 7'h00, 7'h00, 7'h00,  // 15..12
    7'h40, 7'h00, 7'h6F, 7'h7F,  // DASH, BLANK, 9, 8
    7'h07, 7'h7D, 7'h6D, 7'h66,  // 7..4
    7'h4F, 7'h5B, 7'h06, 7'h3F   // 3..0
  };

  // Bits needed to hold 0..n-1; never less than 1 so counters always have a bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while (w < 32 && (32'd1 << w) < n) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/seg7_dec.sv
// Combinational digit-code to segment lookup (active-high, bit 0 = segment a).
module seg7_dec
  import seg7_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[code_i];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment controller: tear-free shadowed digits, one digit per
// scan slot with a dead cycle, internal blink phase and leading-zero blanking.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIG      = 8,
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned SCAN_HZ    = 8_000,
  parameter int unsigned BLINK_HZ   = 2,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4*N_DIG-1:0] digits_in,
  input  logic [N_DIG-1:0]   dp_in,
  input  logic [N_DIG-1:0]   blink_mask,
  input  logic               load,
  input  logic               blank_lz,
  output logic [6:0]         seg_out,
  output logic               dp_out,
  output logic [N_DIG-1:0]   dig_sel,
  output logic               blink_phase,
  output logic               frame_done
);

  localparam int unsigned SCAN_DIV   = CLK_HZ / SCAN_HZ;
  localparam int unsigned BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned ScanW      = clog2(SCAN_DIV);
  localparam int unsigned BlinkW     = clog2(BLINK_HALF);
  localparam int unsigned IdxW       = clog2(N_DIG);

  localparam logic [ScanW-1:0]  ScanMax  = ScanW'(SCAN_DIV - 1);
  localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_HALF - 1);
  localparam logic [IdxW-1:0]   IdxMax   = IdxW'(N_DIG - 1);
  localparam logic              Inv      = (ACTIVE_LOW != 0);

  logic [ScanW-1:0]   scan_cnt_q, scan_cnt_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [BlinkW-1:0]  blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;

  logic [4*N_DIG-1:0] stage_dig_q, stage_dig_d;
  logic [N_DIG-1:0]   stage_dp_q, stage_dp_d;
  logic [N_DIG-1:0]   stage_mask_q, stage_mask_d;
  logic               pending_q, pending_d;
  logic [4*N_DIG-1:0] shadow_dig_q, shadow_dig_d;
  logic [N_DIG-1:0]   shadow_dp_q, shadow_dp_d;
  logic [N_DIG-1:0]   shadow_mask_q, shadow_mask_d;

  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;
  logic [N_DIG-1:0]   dig_sel_q, dig_sel_d;

  logic               tick, frame_end, blink_wrap;
  logic [N_DIG-1:0]   lz_blank;
  logic               zero_run;
  logic [3:0]         sel_code, dec_code;
  logic               sel_dp, sel_mask, sel_lz, blanked;
  logic [N_DIG-1:0]   dig_on;
  logic [6:0]         dec_seg;

  // Scan and blink timebases.
  always_comb begin
    tick          = (scan_cnt_q == ScanMax);
    frame_end     = tick && (idx_q == IdxMax);
    scan_cnt_d    = tick ? '0 : scan_cnt_q + 1'b1;
    idx_d         = idx_q;
    if (tick) begin
      idx_d = frame_end ? '0 : idx_q + 1'b1;
    end
    blink_wrap    = (blink_cnt_q == BlinkMax);
    blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + 1'b1;
    blink_phase_d = blink_phase_q ^ blink_wrap;
  end

  // Staging/shadow: a load arriving on the boundary stays staged for the next frame.
  always_comb begin
    stage_dig_d   = stage_dig_q;
    stage_dp_d    = stage_dp_q;
    stage_mask_d  = stage_mask_q;
    pending_d     = pending_q;
    shadow_dig_d  = shadow_dig_q;
    shadow_dp_d   = shadow_dp_q;
    shadow_mask_d = shadow_mask_q;
    if (frame_end && pending_q) begin
      shadow_dig_d  = stage_dig_q;
      shadow_dp_d   = stage_dp_q;
      shadow_mask_d = stage_mask_q;
      pending_d     = 1'b0;
    end
    if (load) begin
      stage_dig_d  = digits_in;
      stage_dp_d   = dp_in;
      stage_mask_d = blink_mask;
      pending_d    = 1'b1;
    end
  end

  // Leading-zero run from the leftmost digit down; digit 0 is always shown.
  always_comb begin
    lz_blank = '0;
    zero_run = blank_lz;
    for (int i = int'(N_DIG) - 1; i >= 1; i--) begin
      zero_run    = zero_run & (shadow_dig_q[4*i +: 4] == 4'h0);
      lz_blank[i] = zero_run;
    end
  end

  always_comb begin
    sel_code = BLANK;
    sel_dp   = 1'b0;
    sel_mask = 1'b0;
    sel_lz   = 1'b0;
    dig_on   = '0;
    for (int unsigned i = 0; i < N_DIG; i++) begin
      if (idx_q == IdxW'(i)) begin
        sel_code  = shadow_dig_q[4*i +: 4];
        sel_dp    = shadow_dp_q[i];
        sel_mask  = shadow_mask_q[i];
        sel_lz    = lz_blank[i];
        dig_on[i] = (scan_cnt_q != '0);
      end
    end
    blanked  = (sel_mask && blink_phase_q) || sel_lz;
    dec_code = blanked ? BLANK : sel_code;
  end

  seg7_dec u_dec (
    .code_i (dec_code),
    .seg_o  (dec_seg)
  );

  always_comb begin
    seg_d     = dec_seg ^ {7{Inv}};
    dp_d      = (sel_dp && !blanked) ^ Inv;
    dig_sel_d = dig_on ^ {N_DIG{Inv}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q    <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      stage_dig_q   <= {N_DIG{BLANK}};
      stage_dp_q    <= '0;
      stage_mask_q  <= '0;
      pending_q     <= 1'b0;
      shadow_dig_q  <= {N_DIG{BLANK}};
      shadow_dp_q   <= '0;
      shadow_mask_q <= '0;
      seg_q         <= {7{Inv}};
      dp_q          <= Inv;
      dig_sel_q     <= {N_DIG{Inv}};
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      stage_dig_q   <= stage_dig_d;
      stage_dp_q    <= stage_dp_d;
      stage_mask_q  <= stage_mask_d;
      pending_q     <= pending_d;
      shadow_dig_q  <= shadow_dig_d;
      shadow_dp_q   <= shadow_dp_d;
      shadow_mask_q <= shadow_mask_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      dig_sel_q     <= dig_sel_d;
    end
  end

  assign seg_out     = seg_q;
  assign dp_out      = dp_q;
  assign dig_sel     = dig_sel_q;
  assign blink_phase = blink_phase_q;
  assign frame_done  = frame_end;

endmodule
